// File: rtl/led_pattern_engine_if.sv
// LED pattern engine bus: step source and mode select in, LED bank and reversal pulse out.
// Master drives the inputs; the engine itself sits on the slave side.
interface led_pattern_engine_if #(
    parameter int WIDTH = 16
);
    logic             mode_clock;
    logic [1:0]       SW;
    logic [WIDTH-1:0] LD;
    logic             bounce;

    modport master (output mode_clock, output SW, input LD, input bounce);
    modport slave  (input mode_clock, input SW, output LD, output bounce);
endinterface

// File: rtl/led_pattern_engine.sv
// Bouncing-position LED pattern generator stepped by every edge of an asynchronous
// mode_clock, with the pattern style chosen by an asynchronous 2-bit mode switch.
module led_pattern_engine #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic                 CLOCK,
    input logic                 RESET_N,
    led_pattern_engine_if.slave bus
);
    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] POS_MAX  = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_TURN = PW'(WIDTH - 2);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    logic [SYNC_STAGES-1:0]      mc_sync_p0;
    logic [SYNC_STAGES-1:0][1:0] sw_sync_p0;
    logic                        mc_hist_p1;
    logic                        step_p1;
    logic [1:0]                  sw_s_p1;
    logic                        mode_chg_p1;

    state_t          state, nxt_state;
    logic [PW-1:0]   pos, nxt_pos;
    logic [1:0]      mode_q, nxt_mode;
    logic            nxt_bounce;
    logic [WIDTH-1:0] ld_p2;
    logic            bounce_p2;

    // Bar mode is built one bit wider so that pos=WIDTH-1 yields all ones after truncation.
    function automatic logic [WIDTH-1:0] led_pattern(input logic [1:0] mode, input logic [PW-1:0] p);
        case (mode)
            2'd1:    led_pattern = WIDTH'(1) << p;
            2'd2:    led_pattern = WIDTH'(((WIDTH+1)'(2) << p) - (WIDTH+1)'(1));
            2'd3:    led_pattern = ~(WIDTH'(1) << p);
            default: led_pattern = '0;
        endcase
    endfunction

    // p0: synchronizer chains for the asynchronous inputs
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            mc_sync_p0 <= '0;
            sw_sync_p0 <= '0;
            mc_hist_p1 <= 1'b0;
        end else begin
            mc_sync_p0 <= {mc_sync_p0[SYNC_STAGES-2:0], bus.mode_clock};
            sw_sync_p0 <= {sw_sync_p0[SYNC_STAGES-2:0], bus.SW};
            mc_hist_p1 <= mc_sync_p0[SYNC_STAGES-1];
        end
    end

    // p1: edge detect and mode-change detect on synchronized values
    assign step_p1     = mc_sync_p0[SYNC_STAGES-1] ^ mc_hist_p1;
    assign sw_s_p1     = sw_sync_p0[SYNC_STAGES-1];
    assign mode_chg_p1 = (sw_s_p1 != mode_q);

    always_comb begin
        nxt_state  = state;
        nxt_pos    = pos;
        nxt_mode   = mode_q;
        nxt_bounce = 1'b0;
        if (mode_chg_p1) begin
            // A step landing in the same cycle as a mode change is dropped.
            nxt_mode  = sw_s_p1;
            nxt_pos   = '0;
            nxt_state = (sw_s_p1 == 2'd0) ? IDLE : UP;
        end else if (step_p1) begin
            case (state)
                UP: begin
                    if (pos == POS_MAX) begin
                        nxt_pos    = POS_TURN;
                        nxt_state  = DOWN;
                        nxt_bounce = 1'b1;
                    end else begin
                        nxt_pos = pos + POS_ONE;
                    end
                end
                DOWN: begin
                    if (pos == '0) begin
                        nxt_pos    = POS_ONE;
                        nxt_state  = UP;
                        nxt_bounce = 1'b1;
                    end else begin
                        nxt_pos = pos - POS_ONE;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_pos   = '0;
                end
            endcase
        end
    end

    // p2: state and registered LED / bounce outputs
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            pos       <= '0;
            mode_q    <= 2'd0;
            ld_p2     <= '0;
            bounce_p2 <= 1'b0;
        end else begin
            state     <= nxt_state;
            pos       <= nxt_pos;
            mode_q    <= nxt_mode;
            ld_p2     <= led_pattern(nxt_mode, nxt_pos);
            bounce_p2 <= nxt_bounce;
        end
    end

    assign bus.LD     = ld_p2;
    assign bus.bounce = bounce_p2;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed vector table, reset sequences
// and randomized operations compared against a step-count model of the bounce sweep.
module tb_led_pattern_engine;
    localparam int W = 16;
    localparam int K_SW = 0, K_TOG = 1, K_BOTH = 2;

    logic CLOCK;
    logic RESET_N;
    led_pattern_engine_if #(.WIDTH(W)) bus();

    led_pattern_engine #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int          kind;
        logic [1:0]  sw;
        int          n;
        logic [15:0] exp_ld;
        logic        exp_b;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   m_mode = 0;
    int   m_k = 0;
    logic obs_b;
    vec_t tbl[$];

    // Sweep position after k steps: triangle wave of period 2*(W-1).
    function automatic int mpos(input int k);
        int p = 2 * (W - 1);
        int m = k % p;
        return (m <= W - 1) ? m : p - m;
    endfunction

    // Step number k reverses direction when the previous position was an end point.
    function automatic logic mbounce(input int k);
        int pm = (k - 1) % (2 * (W - 1));
        return (pm == W - 1) || (pm == 0 && k > 1);
    endfunction

    function automatic logic [15:0] mld(input int mode, input int k);
        int p = mpos(k);
        case (mode)
            1:       return 16'((1 << p) & 32'hFFFF);
            2:       return 16'(((2 << p) - 1) & 32'hFFFF);
            3:       return 16'(~(1 << p) & 32'hFFFF);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_apply(input int kind, input logic [1:0] sw, output logic exp_b);
        exp_b = 1'b0;
        if (kind != K_TOG && int'(sw) != m_mode) begin
            m_mode = int'(sw);
            m_k    = 0;
        end else if (kind != K_SW && m_mode != 0) begin
            m_k++;
            exp_b = mbounce(m_k);
        end
    endtask

    // Called between clock edges; inputs change now, outputs must move on the 3rd rising edge.
    task automatic do_op(input int kind, input logic [1:0] sw);
        logic [15:0] old_ld;
        logic        exp_b;
        old_ld = mld(m_mode, m_k);
        if (kind != K_TOG) bus.SW = sw;
        if (kind != K_SW) bus.mode_clock = ~bus.mode_clock;
        model_apply(kind, sw, exp_b);
        @(posedge CLOCK); @(posedge CLOCK); @(negedge CLOCK);
        chk("ld_before_3rd_edge", 32'(bus.LD), 32'(old_ld));
        chk("bounce_before_3rd_edge", 32'(bus.bounce), 32'd0);
        @(posedge CLOCK); @(negedge CLOCK);
        chk("ld_at_3rd_edge", 32'(bus.LD), 32'(mld(m_mode, m_k)));
        chk("bounce_at_3rd_edge", 32'(bus.bounce), 32'(exp_b));
        obs_b = bus.bounce;
        @(posedge CLOCK); @(negedge CLOCK);
        chk("bounce_one_cycle", 32'(bus.bounce), 32'd0);
    endtask

    initial begin
        RESET_N        = 1'b1;
        bus.SW         = 2'd1;
        bus.mode_clock = 1'b0;
        #1 RESET_N = 1'b0;
        #1;
        chk("reset_ld_no_clock", 32'(bus.LD), 32'd0);
        chk("reset_bounce_no_clock", 32'(bus.bounce), 32'd0);
        repeat (3) @(negedge CLOCK);
        bus.SW  = 2'd0;
        RESET_N = 1'b1;
        repeat (4) @(negedge CLOCK);
        chk("idle_after_release", 32'(bus.LD), 32'd0);

        tbl.push_back('{K_TOG,  2'd0, 10, 16'h0000, 1'b0});
        tbl.push_back('{K_SW,   2'd1, 1,  16'h0001, 1'b0});
        tbl.push_back('{K_TOG,  2'd1, 15, 16'h8000, 1'b0});
        tbl.push_back('{K_TOG,  2'd1, 1,  16'h4000, 1'b1});
        tbl.push_back('{K_TOG,  2'd1, 14, 16'h0001, 1'b0});
        tbl.push_back('{K_TOG,  2'd1, 1,  16'h0002, 1'b1});
        tbl.push_back('{K_SW,   2'd2, 1,  16'h0001, 1'b0});
        tbl.push_back('{K_TOG,  2'd2, 4,  16'h001F, 1'b0});
        tbl.push_back('{K_TOG,  2'd2, 11, 16'hFFFF, 1'b0});
        tbl.push_back('{K_TOG,  2'd2, 1,  16'h7FFF, 1'b1});
        tbl.push_back('{K_SW,   2'd3, 1,  16'hFFFE, 1'b0});
        tbl.push_back('{K_TOG,  2'd3, 1,  16'hFFFD, 1'b0});
        tbl.push_back('{K_SW,   2'd1, 1,  16'h0001, 1'b0});
        tbl.push_back('{K_TOG,  2'd1, 5,  16'h0020, 1'b0});
        tbl.push_back('{K_BOTH, 2'd2, 1,  16'h0001, 1'b0});
        tbl.push_back('{K_TOG,  2'd2, 1,  16'h0003, 1'b0});
        tbl.push_back('{K_SW,   2'd1, 1,  16'h0001, 1'b0});
        tbl.push_back('{K_TOG,  2'd1, 10, 16'h0400, 1'b0});

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) do_op(tbl[i].kind, tbl[i].sw);
            chk($sformatf("tbl%0d_ld", i), 32'(bus.LD), 32'(tbl[i].exp_ld));
            chk($sformatf("tbl%0d_bounce", i), 32'(obs_b), 32'(tbl[i].exp_b));
        end

        // Reset mid-sweep: LD clears without a clock, then mode 1 is re-entered.
        RESET_N = 1'b0;
        #1;
        chk("midsweep_reset_ld", 32'(bus.LD), 32'd0);
        chk("midsweep_reset_bounce", 32'(bus.bounce), 32'd0);
        #1 RESET_N = 1'b1;
        m_mode = 1;
        m_k    = 0;
        @(posedge CLOCK); @(posedge CLOCK); @(negedge CLOCK);
        chk("reentry_before_3rd_edge", 32'(bus.LD), 32'd0);
        @(posedge CLOCK); @(negedge CLOCK);
        chk("reentry_at_3rd_edge", 32'(bus.LD), 32'h0001);
        do_op(K_TOG, 2'd1);
        chk("reentry_first_step", 32'(bus.LD), 32'h0002);

        for (int r = 0; r < 200; r++) begin
            int          pick;
            int          kind;
            logic [1:0]  sw;
            pick = int'($urandom_range(0, 99));
            kind = (pick < 60) ? K_TOG : (pick < 85) ? K_SW : K_BOTH;
            sw   = 2'($urandom_range(0, 3));
            if (kind == K_TOG) sw = bus.SW;
            do_op(kind, sw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
